// File: rtl/vga_sync_gen.sv
// Raster timing generator: beam position, sync pulses, visible-area flag and
// a completed-frame counter for the downstream pixel pattern stage.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned FRAME_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    output logic [9:0]         hpos,
    output logic [9:0]         vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned POS_W        = 10;
    localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Position counters are 10 bits wide, so longer rasters cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_range_check
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 1024");
    end

    logic [POS_W-1:0]   hpos_q, hpos_d;
    logic [POS_W-1:0]   vpos_q, vpos_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               h_last;
    logic               v_last;

    assign h_last = (hpos_q == POS_W'(H_TOTAL - 1));
    assign v_last = (vpos_q == POS_W'(V_TOTAL - 1));

    // Next-state: raster scan advance, frame counted on the wrap to (0,0).
    always_comb begin
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        frame_d = frame_q;
        if (ena) begin
            if (h_last) begin
                hpos_d = '0;
                if (v_last) begin
                    vpos_d  = '0;
                    frame_d = frame_q + FRAME_W'(1);
                end else begin
                    vpos_d = vpos_q + POS_W'(1);
                end
            end else begin
                hpos_d = hpos_q + POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            frame_q <= '0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            frame_q <= frame_d;
        end
    end

    // Zero-latency decodes so consumers see sync/visibility aligned with position.
    logic in_hsync;
    logic in_vsync;

    assign in_hsync = (32'(hpos_q) >= H_SYNC_START) && (32'(hpos_q) < H_SYNC_END);
    assign in_vsync = (32'(vpos_q) >= V_SYNC_START) && (32'(vpos_q) < V_SYNC_END);

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_count = frame_q;
    assign hsync       = in_hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync       = in_vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign display_on  = (32'(hpos_q) < H_DISPLAY) && (32'(vpos_q) < V_DISPLAY);
    assign line_start  = ena && (hpos_q == '0);
    assign frame_start = line_start && (vpos_q == '0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size 640x480 timing instance plus a tiny 8x8 raster
// instance used for frame-level and wrap behaviour.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, ena_a, rst_b, ena_b;
    logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
    logic       hsync_a, vsync_a, disp_a, ls_a, fs_a;
    logic       hsync_b, vsync_b, disp_b, ls_b, fs_b;
    logic [7:0] fc_a, fc_b;

    vga_sync_gen u_dut_a (
        .clk(clk), .rst(rst_a), .ena(ena_a),
        .hpos(hpos_a), .vpos(vpos_a), .hsync(hsync_a), .vsync(vsync_a),
        .display_on(disp_a), .line_start(ls_a), .frame_start(fs_a),
        .frame_count(fc_a)
    );

    // 8x8 raster: visible 4x4, sync at columns/lines 5..6.
    vga_sync_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE(1'b0), .FRAME_W(8)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .ena(ena_b),
        .hpos(hpos_b), .vpos(vpos_b), .hsync(hsync_b), .vsync(vsync_b),
        .display_on(disp_b), .line_start(ls_b), .frame_start(fs_b),
        .frame_count(fc_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int hs_low, hs_first, hs_last, disp_cnt, ls_cnt;
    int vs_low, hs_low_b, disp_b_cnt, disp_lower, fs_cnt;
    int hold_err;

    initial begin
        rst_a = 1'b1; ena_a = 1'b1;
        rst_b = 1'b1; ena_b = 1'b0;

        // Reset/idle on full-size timing
        tick(3);
        rst_a = 1'b0;
        check_eq("rst_hpos", 32'(hpos_a), 0);
        check_eq("rst_vpos", 32'(vpos_a), 0);
        check_eq("rst_fc", 32'(fc_a), 0);
        check_eq("rst_disp", 32'(disp_a), 1);
        check_eq("rst_hsync", 32'(hsync_a), 1);
        check_eq("rst_vsync", 32'(vsync_a), 1);
        check_eq("rst_ls", 32'(ls_a), 1);
        check_eq("rst_fs", 32'(fs_a), 1);
        tick(1);
        check_eq("first_adv_hpos", 32'(hpos_a), 1);
        check_eq("first_adv_ls", 32'(ls_a), 0);
        check_eq("first_adv_fs", 32'(fs_a), 0);

        // Horizontal timing: samples hpos 1..799 of line 0, then (0,1)
        hs_low = 0; hs_first = -1; hs_last = -1; disp_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (hsync_a == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(hpos_a);
                hs_last = int'(hpos_a);
            end
            if (disp_a) disp_cnt++;
            if (ls_a) ls_cnt++;
            if (i == 638) check_eq("disp_at_639", 32'(disp_a), 1);
            if (i == 639) check_eq("disp_at_640", 32'(disp_a), 0);
            if (i == 798) begin
                check_eq("pre_wrap_hpos", 32'(hpos_a), 799);
                check_eq("pre_wrap_vpos", 32'(vpos_a), 0);
            end
            if (i == 799) begin
                check_eq("post_wrap_hpos", 32'(hpos_a), 0);
                check_eq("post_wrap_vpos", 32'(vpos_a), 1);
            end
            tick(1);
        end
        check_eq("hsync_low_cycles", 32'(hs_low), 96);
        check_eq("hsync_first", 32'(hs_first), 656);
        check_eq("hsync_last", 32'(hs_last), 751);
        check_eq("disp_cycles_line", 32'(disp_cnt), 640);
        check_eq("line_start_per_line", 32'(ls_cnt), 1);

        // Enable hold at (100,3): now at (1,1)
        tick(1699);
        check_eq("hold_entry_hpos", 32'(hpos_a), 100);
        check_eq("hold_entry_vpos", 32'(vpos_a), 3);
        ena_a = 1'b0;
        hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (hpos_a !== 10'd100 || vpos_a !== 10'd3 || fc_a !== 8'd0 ||
                hsync_a !== 1'b1 || ls_a !== 1'b0)
                hold_err++;
        end
        check_eq("hold_frozen_cycles_bad", 32'(hold_err), 0);
        check_eq("hold_hpos", 32'(hpos_a), 100);
        check_eq("hold_vsync", 32'(vsync_a), 1);
        check_eq("hold_disp", 32'(disp_a), 1);
        ena_a = 1'b1;
        tick(1);
        check_eq("resume_hpos", 32'(hpos_a), 101);
        tick(699);
        check_eq("line4_hpos", 32'(hpos_a), 0);
        check_eq("line4_vpos", 32'(vpos_a), 4);
        ena_a = 1'b0;
        #1;
        check_eq("ls_gated_by_ena", 32'(ls_a), 0);
        ena_a = 1'b1;
        #1;
        check_eq("ls_with_ena", 32'(ls_a), 1);
        ena_a = 1'b0;

        // Vertical timing on the 8x8 raster (64 cycles per frame)
        ena_b = 1'b1;
        tick(3);
        rst_b = 1'b0;
        check_eq("b_rst_hpos", 32'(hpos_b), 0);
        check_eq("b_rst_fs", 32'(fs_b), 1);
        vs_low = 0; hs_low_b = 0; disp_b_cnt = 0; disp_lower = 0; fs_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (vsync_b == 1'b0) vs_low++;
            if (hsync_b == 1'b0) hs_low_b++;
            if (disp_b) disp_b_cnt++;
            if (disp_b && vpos_b >= 10'd4) disp_lower++;
            if (fs_b) fs_cnt++;
            if (i == 40) check_eq("b_vsync_line5", 32'(vsync_b), 0);
            if (i == 56) check_eq("b_vsync_line7", 32'(vsync_b), 1);
            tick(1);
        end
        check_eq("b_vsync_low_cycles", 32'(vs_low), 16);
        check_eq("b_hsync_low_cycles", 32'(hs_low_b), 16);
        check_eq("b_disp_cycles", 32'(disp_b_cnt), 16);
        check_eq("b_disp_in_vblank", 32'(disp_lower), 0);
        check_eq("b_fs_per_frame", 32'(fs_cnt), 1);
        check_eq("b_frame1_fs", 32'(fs_b), 1);
        check_eq("b_frame1_hpos", 32'(hpos_b), 0);
        check_eq("b_frame1_vpos", 32'(vpos_b), 0);
        check_eq("b_frame1_fc", 32'(fc_b), 1);

        // Frame counter wrap
        tick(254 * 64);
        check_eq("b_fc_255_start", 32'(fc_b), 255);
        tick(63);
        check_eq("b_last_hpos", 32'(hpos_b), 7);
        check_eq("b_last_vpos", 32'(vpos_b), 7);
        check_eq("b_fc_255_end", 32'(fc_b), 255);
        tick(1);
        check_eq("b_fc_wrap", 32'(fc_b), 0);
        check_eq("b_wrap_vpos", 32'(vpos_b), 0);

        // Mid-frame reset at (6,5), frame 5, ena low
        tick(5 * 64 + 5 * 8 + 6);
        ena_b = 1'b0;
        check_eq("b_pre_rst_fc", 32'(fc_b), 5);
        check_eq("b_pre_rst_hpos", 32'(hpos_b), 6);
        check_eq("b_pre_rst_vpos", 32'(vpos_b), 5);
        check_eq("b_pre_rst_hsync", 32'(hsync_b), 0);
        check_eq("b_pre_rst_vsync", 32'(vsync_b), 0);
        rst_b = 1'b1;
        tick(1);
        rst_b = 1'b0;
        check_eq("b_mid_rst_hpos", 32'(hpos_b), 0);
        check_eq("b_mid_rst_vpos", 32'(vpos_b), 0);
        check_eq("b_mid_rst_fc", 32'(fc_b), 0);
        check_eq("b_mid_rst_hsync", 32'(hsync_b), 1);
        check_eq("b_mid_rst_vsync", 32'(vsync_b), 1);
        check_eq("b_mid_rst_ls", 32'(ls_b), 0);
        check_eq("b_mid_rst_fs", 32'(fs_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Raster timing generator that sits directly upstream of the munching-squares pixel stage inside tt_um_bytex64_munch. It produces the beam position, the sync pulses, the visible-area flag and an animation frame counter. The pattern logic consumes these to compute its colour outputs. The default timing is 640x480@60 Hz from a 25.175 MHz (nominally 25 MHz) clock.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, logic level of hsync/vsync during the sync pulse
FRAME_W, 8, width of frame_count

Ports:
clk  input  1  pixel clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
ena  input  1  advance enable; counters hold when low
hpos  output  10  current column, 0..H_TOTAL-1
vpos  output  10  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE
vsync  output  1  vertical sync, polarity per SYNC_ACTIVE
display_on  output  1  high while hpos<H_DISPLAY and vpos<V_DISPLAY
line_start  output  1  one-cycle strobe at hpos==0
frame_start  output  1  one-cycle strobe at hpos==0 and vpos==0
frame_count  output  FRAME_W  completed-frame counter, wraps modulo 2^FRAME_W

Behaviour:
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = sum of the V_* parameters (525). Both must be ≤1024; elaboration fails otherwise.
- State: hpos, vpos and frame_count are registers. All other outputs are combinational decodes of the registers (zero latency relative to hpos/vpos).
- Reset (rst=1 at a clock edge): hpos=0, vpos=0, frame_count=0. Reset takes priority over ena.
- Reset decode values: display_on=1, line_start=ena, frame_start=ena, hsync=vsync=~SYNC_ACTIVE.
- Advance (ena=1, rst=0):
  - If hpos<H_TOTAL-1: hpos+1.
  - Else hpos=0, and vpos advances: vpos+1 if vpos<V_TOTAL-1, else vpos=0 and frame_count+1.
- frame_count increments exactly on the edge where the beam goes from (H_TOTAL-1, V_TOTAL-1) to (0,0). It wraps 2^FRAME_W-1 -> 0 silently.
- ena=0: all registers hold. line_start and frame_start are forced to 0 while ena=0, so each strobe asserts for exactly one enabled cycle per position. Sync and display_on keep reflecting the held position.
- hsync = SYNC_ACTIVE when H_DISPLAY+H_FRONT ≤ hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751); otherwise ~SYNC_ACTIVE.
- vsync = SYNC_ACTIVE when V_DISPLAY+V_FRONT ≤ vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), for the whole line including blanking; otherwise ~SYNC_ACTIVE.
- Reset mid-frame: on the next edge the position returns to (0,0) and frame_count to 0. No partial frame is counted.
- Registers outside the valid range cannot occur after reset. The counters need no recovery logic beyond the wrap compares, which use equality to H_TOTAL-1 and V_TOTAL-1.
- Counter arithmetic is 10-bit unsigned; frame_count is FRAME_W-bit unsigned.
- Downstream contract: the pixel stage may sample hpos/vpos/display_on in the same cycle. Its colour outputs must be zero whenever display_on=0.

Test Plan:
1. Reset/idle: hold rst=1 for 3 cycles with ena=1, then release. Expect hpos=0, vpos=0, frame_count=0, display_on=1, hsync=vsync=1, line_start=frame_start=1 in the first cycle. The next cycle has hpos=1 and both strobes 0.
2. Horizontal timing: run one line with ena=1.
   - hsync is 0 for exactly hpos 656..751 (96 cycles).
   - display_on drops at hpos=640.
   - hpos wraps 799->0 and vpos goes 0->1 on the same edge.
   - line_start is high for 1 cycle per 800.
3. Vertical timing: run one frame (420000 cycles). vsync is low for lines 490..491 (1600 cycles). display_on is 0 for all of vpos≥480. At cycle 420000, frame_start=1, the position is (0,0) and frame_count=1.
4. Frame wrap: run 256 frames with FRAME_W=8. frame_count reads 255 during the final frame, then reads 0 after the (799,524)->(0,0) edge.
5. Enable hold: at hpos=100, vpos=3, drop ena for 10 cycles. hpos, vpos and frame_count stay frozen and hsync stays 1. With ena=0 at hpos=0, line_start is 0. When ena returns, hpos resumes at 101.
6. Reset mid-operation: assert rst for 1 cycle at (700,491) with frame_count=5 and ena=0. Next cycle: hpos=0, vpos=0, frame_count=0, vsync=1, hsync=1.
